// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: merges the unstallable pipeline writeback and the
// valid/ready LLU result into one registered write port. Optional macro: REGFILE_INIT_EN.
module regfile_wb_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pipe_we,
  input  logic [ADDR_W-1:0] i_pipe_addr,
  input  logic [DATA_W-1:0] i_pipe_data,
  input  logic              i_llu_valid,
  input  logic [ADDR_W-1:0] i_llu_addr,
  input  logic [DATA_W-1:0] i_llu_data,
  output logic              o_llu_ready,
  output logic              o_w_en,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [DATA_W-1:0] o_w_data,
  output logic              o_stall_req,
  output logic              o_init_busy,
  output logic              o_proto_err
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAVOR} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

`ifdef REGFILE_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif

  state_t              r_state;
  logic [3:0]          r_starve_cnt;
  logic                r_stall;
  logic                r_proto_err;
  logic                r_w_en;
  logic [ADDR_W-1:0]   r_w_addr;
  logic [DATA_W-1:0]   r_w_data;

  logic                w_pipe_nz;
  logic                w_llu_nz;
  logic                w_addr_eq;
  logic                w_llu_ready;
  logic                w_sel_en;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic [3:0]          w_starve_nxt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_pipe_nz    = i_pipe_we & (i_pipe_addr != '0);
    w_llu_nz     = (i_llu_addr != '0);
    w_addr_eq    = (i_pipe_addr == i_llu_addr);
    w_llu_ready  = 1'b0;
    w_sel_en     = 1'b0;
    w_sel_addr   = i_pipe_addr;
    w_sel_data   = i_pipe_data;
    w_starve_nxt = r_starve_cnt;

    case (r_state)
      ST_RUN: begin
        // Same nonzero target: the pipeline value is younger, so the LLU value is discarded.
        w_llu_ready = i_llu_valid & (~w_pipe_nz | w_addr_eq);
        if (w_pipe_nz) begin
          w_sel_en = 1'b1;
        end else if (w_llu_ready & w_llu_nz) begin
          w_sel_en   = 1'b1;
          w_sel_addr = i_llu_addr;
          w_sel_data = i_llu_data;
        end
      end
      ST_FAVOR: begin
        w_llu_ready = i_llu_valid;
        w_sel_en    = i_llu_valid & w_llu_nz;
        w_sel_addr  = i_llu_addr;
        w_sel_data  = i_llu_data;
      end
      default: ;
    endcase

    w_llu_ready = w_llu_ready & i_rst_n;

    if (!i_llu_valid || w_llu_ready || r_state == ST_INIT) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt < LIMIT) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

`ifdef REGFILE_INIT_EN
  logic [5:0] r_init_cnt;
  logic       r_init_busy;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RST_STATE;
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
      r_proto_err  <= 1'b0;
      r_w_en       <= 1'b0;
      r_w_addr     <= '0;
      r_w_data     <= '0;
`ifdef REGFILE_INIT_EN
      r_init_cnt   <= '0;
      r_init_busy  <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples this cycle's values.
      r_starve_cnt <= w_starve_nxt;
      r_w_en       <= w_sel_en;
      if (w_sel_en) begin
        r_w_addr <= w_sel_addr;
        r_w_data <= w_sel_data;
      end
      if (r_stall && i_pipe_we) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        ST_INIT: begin
`ifdef REGFILE_INIT_EN
          if (r_init_cnt == 6'd32) begin
            r_state     <= ST_RUN;
            r_init_busy <= 1'b0;
          end else begin
            r_w_en     <= 1'b1;
            r_w_addr   <= ADDR_W'(r_init_cnt[4:0]);
            r_w_data   <= '0;
            r_init_cnt <= r_init_cnt + 6'd1;
          end
`else
          r_state <= ST_RUN;
`endif
        end
        ST_RUN: begin
          if (w_starve_nxt == LIMIT) begin
            r_state <= ST_FAVOR;
            r_stall <= 1'b1;
          end
        end
        ST_FAVOR: begin
          if (w_llu_ready) begin
            r_state <= ST_RUN;
            r_stall <= 1'b0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_llu_ready = w_llu_ready;
  assign o_w_en      = r_w_en;
  assign o_w_addr    = r_w_addr;
  assign o_w_data    = r_w_data;
  assign o_stall_req = r_stall;
  assign o_proto_err = r_proto_err;
`ifdef REGFILE_INIT_EN
  assign o_init_busy = r_init_busy;
`else
  assign o_init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: vector table plus hand-written
// sequences for zero-fill, starvation and asynchronous reset.
module tb_regfile_wb_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_pipe_we;
  logic [4:0]  i_pipe_addr;
  logic [31:0] i_pipe_data;
  logic        i_llu_valid;
  logic [4:0]  i_llu_addr;
  logic [31:0] i_llu_data;
  logic        o_llu_ready;
  logic        o_w_en;
  logic [4:0]  o_w_addr;
  logic [31:0] o_w_data;
  logic        o_stall_req;
  logic        o_init_busy;
  logic        o_proto_err;

  regfile_wb_scheduler #(.STARVE_LIMIT(4), .ADDR_W(5), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pipe_we(i_pipe_we), .i_pipe_addr(i_pipe_addr), .i_pipe_data(i_pipe_data),
    .i_llu_valid(i_llu_valid), .i_llu_addr(i_llu_addr), .i_llu_data(i_llu_data),
    .o_llu_ready(o_llu_ready), .o_w_en(o_w_en), .o_w_addr(o_w_addr), .o_w_data(o_w_data),
    .o_stall_req(o_stall_req), .o_init_busy(o_init_busy), .o_proto_err(o_proto_err)
  );

  always #5 i_clk = ~i_clk;

`ifdef REGFILE_INIT_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        rdy;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic        perr;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  vec_t        vecs[11];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [4:0]  last_a  = '0;
  logic [31:0] last_d  = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic rdy, input logic wen, input logic [4:0] wa,
                              input logic [31:0] wd, input logic st, input logic pe);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld;
    v.rdy = rdy; v.wen = wen; v.wa = wa; v.wd = wd; v.stall = st; v.perr = pe;
    return v;
  endfunction

  // Called at a falling edge: drives one cycle of stimulus, checks the combinational
  // ready, then checks the registered write one cycle later against the scoreboard.
  task automatic step(input vec_t v, input string nm);
    wr_t e;
    i_pipe_we = v.pwe; i_pipe_addr = v.pa; i_pipe_data = v.pd;
    i_llu_valid = v.lv; i_llu_addr = v.la; i_llu_data = v.ld;
    #1;
    check({nm, ".ready"}, 32'(o_llu_ready), 32'(v.rdy));
    sb.push_back('{en: v.wen, addr: v.wa, data: v.wd});
    @(posedge i_clk); #1;
    e = sb.pop_front();
    if (e.en) begin
      last_a = e.addr;
      last_d = e.data;
    end
    check({nm, ".w_en"},   32'(o_w_en),      32'(e.en));
    check({nm, ".w_addr"}, 32'(o_w_addr),    32'(last_a));
    check({nm, ".w_data"}, o_w_data,         last_d);
    check({nm, ".stall"},  32'(o_stall_req), 32'(v.stall));
    check({nm, ".perr"},   32'(o_proto_err), 32'(v.perr));
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_pipe_we = 1'b0; i_pipe_addr = '0; i_pipe_data = '0;
    i_llu_valid = 1'b0; i_llu_addr = '0; i_llu_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    //            pwe pa  pd            lv la  ld            rdy wen wa  wd            st pe
    vecs[0]  = mk(0,  0,  32'h0,        0, 0,  32'h0,        0,  0,  0,  32'h0,        0, 0);
    vecs[1]  = mk(1,  5,  32'hDEADBEEF, 0, 0,  32'h0,        0,  1,  5,  32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(1,  3,  32'h11,       1, 7,  32'h22,       0,  1,  3,  32'h11,       0, 0);
    vecs[3]  = mk(0,  0,  32'h0,        1, 7,  32'h22,       1,  1,  7,  32'h22,       0, 0);
    vecs[4]  = mk(1,  9,  32'hAA,       1, 9,  32'hBB,       1,  1,  9,  32'hAA,       0, 0);
    vecs[5]  = mk(0,  0,  32'h0,        1, 0,  32'h55,       1,  0,  0,  32'h0,        0, 0);
    vecs[6]  = mk(1,  0,  32'h66,       0, 0,  32'h0,        0,  0,  0,  32'h0,        0, 0);
    vecs[7]  = mk(1,  0,  32'h66,       1, 12, 32'h77,       1,  1,  12, 32'h77,       0, 0);
    vecs[8]  = mk(0,  0,  32'h0,        1, 31, 32'hFFFFFFFF, 1,  1,  31, 32'hFFFFFFFF, 0, 0);
    vecs[9]  = mk(1,  1,  32'h1234,     1, 0,  32'h99,       0,  1,  1,  32'h1234,     0, 0);
    vecs[10] = mk(0,  0,  32'h0,        0, 0,  32'h0,        0,  0,  0,  32'h0,        0, 0);

    idle_inputs();
    i_rst_n = 1'b0;
    i_llu_valid = 1'b1;
    #12;
    check("rst.w_en",   32'(o_w_en),      32'd0);
    check("rst.w_addr", 32'(o_w_addr),    32'd0);
    check("rst.w_data", o_w_data,         32'd0);
    check("rst.stall",  32'(o_stall_req), 32'd0);
    check("rst.perr",   32'(o_proto_err), 32'd0);
    check("rst.ready",  32'(o_llu_ready), 32'd0);
    check("rst.busy",   32'(o_init_busy), 32'(EXP_BUSY_RST));
    @(negedge i_clk);
    idle_inputs();
    i_rst_n = 1'b1;

`ifdef REGFILE_INIT_EN
    i_pipe_we = 1'b1; i_pipe_addr = 5'd8; i_pipe_data = 32'h88;
    i_llu_valid = 1'b1; i_llu_addr = 5'd4; i_llu_data = 32'h99;
    for (int i = 0; i < 32; i++) begin
      @(posedge i_clk); #1;
      check($sformatf("init%0d.w_en", i),   32'(o_w_en),      32'd1);
      check($sformatf("init%0d.w_addr", i), 32'(o_w_addr),    32'(i));
      check($sformatf("init%0d.w_data", i), o_w_data,         32'd0);
      check($sformatf("init%0d.busy", i),   32'(o_init_busy), 32'd1);
      check($sformatf("init%0d.ready", i),  32'(o_llu_ready), 32'd0);
    end
    @(posedge i_clk); #1;
    check("init_done.busy", 32'(o_init_busy), 32'd0);
    check("init_done.w_en", 32'(o_w_en),      32'd0);
    last_a = 5'd31;
    last_d = 32'd0;
    @(negedge i_clk);
    idle_inputs();
`else
    @(posedge i_clk); #1;
    check("run.busy", 32'(o_init_busy), 32'd0);
    @(negedge i_clk);
`endif

    for (int i = 0; i < 11; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Starvation: LLU blocked by four pipeline writes, then favoured.
    step(mk(1, 2, 32'h200, 1, 20, 32'hCAFE, 0, 1, 2,  32'h200,  0, 0), "starve0");
    step(mk(1, 3, 32'h300, 1, 20, 32'hCAFE, 0, 1, 3,  32'h300,  0, 0), "starve1");
    step(mk(1, 4, 32'h400, 1, 20, 32'hCAFE, 0, 1, 4,  32'h400,  0, 0), "starve2");
    step(mk(1, 5, 32'h500, 1, 20, 32'hCAFE, 0, 1, 5,  32'h500,  1, 0), "starve3");
    step(mk(1, 6, 32'h600, 1, 20, 32'hCAFE, 1, 1, 20, 32'hCAFE, 0, 1), "favor");
    step(mk(0, 0, 32'h0,   0, 0,  32'h0,    0, 0, 0,  32'h0,    0, 1), "after_favor");

    // Asynchronous reset while a write is on the outputs.
    i_pipe_we = 1'b1; i_pipe_addr = 5'd14; i_pipe_data = 32'hABCD;
    @(posedge i_clk); #1;
    check("inflight.w_en", 32'(o_w_en), 32'd1);
    i_llu_valid = 1'b1; i_llu_addr = 5'd3; i_llu_data = 32'h5;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst.w_en",   32'(o_w_en),      32'd0);
    check("arst.w_addr", 32'(o_w_addr),    32'd0);
    check("arst.w_data", o_w_data,         32'd0);
    check("arst.stall",  32'(o_stall_req), 32'd0);
    check("arst.perr",   32'(o_proto_err), 32'd0);
    check("arst.ready",  32'(o_llu_ready), 32'd0);
    check("arst.busy",   32'(o_init_busy), 32'(EXP_BUSY_RST));
    @(negedge i_clk);
    idle_inputs();
    i_rst_n = 1'b1;
    last_a = '0;
    last_d = '0;

`ifdef REGFILE_INIT_EN
    @(posedge i_clk); #1;
    check("reinit.w_en",   32'(o_w_en),   32'd1);
    check("reinit.w_addr", 32'(o_w_addr), 32'd0);
`else
    step(mk(1, 17, 32'h1717, 0, 0, 32'h0, 0, 1, 17, 32'h1717, 0, 0), "post_rst");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
